// File: rtl/ram_ctrl.sv
// Synchronous word RAM with configurable read latency and a one-cycle mem_ready handshake.
module ram_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_ready,
  output logic                  addr_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ready_q, ready_d;
  logic                    aerr_q, aerr_d;
  logic                    we;
  logic                    reqErr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign reqErr    = |address[31:ADDR_WIDTH];
  assign data_out  = data_q;
  assign mem_ready = ready_q;
  assign addr_err  = aerr_q;

  // Writes complete on the acceptance edge; reads either finish at once
  // (latency 1) or count down in RD_WAIT before loading data_out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    data_d  = data_q;
    ready_d = 1'b0;
    aerr_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (write || read) begin
          addr_d = address[ADDR_WIDTH-1:0];
          err_d  = reqErr;
          if (write) begin
            we      = !reqErr;
            state_d = DONE;
            ready_d = 1'b1;
            aerr_d  = reqErr;
          end else if (READ_LATENCY == 1) begin
            data_d  = reqErr ? '0 : mem[address[ADDR_WIDTH-1:0]];
            state_d = DONE;
            ready_d = 1'b1;
            aerr_d  = reqErr;
          end else begin
            cnt_d   = 3'(READ_LATENCY - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd1) begin
          data_d  = err_q ? '0 : mem[addr_q];
          state_d = DONE;
          ready_d = 1'b1;
          aerr_d  = err_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: state_d = HOLD;
      HOLD: begin
        if (!read && !write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      aerr_q  <= aerr_d;
    end
  end

  // The array has no reset; clr only blocks a write on its own edge.
  always_ff @(posedge clk) begin
    if (we && !clr) mem[address[ADDR_WIDTH-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: two instances (read latency 1 and 4) driven with identical requests
// and checked against a word-array reference model.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic        rd;
  logic        wr;
  logic [31:0] dataOutA, dataOutB;
  logic        readyA, readyB;
  logic        errA, errB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(1)) dutA (
    .clk(clk), .clr(clr), .address(address), .data_in(dataIn), .read(rd), .write(wr),
    .data_out(dataOutA), .mem_ready(readyA), .addr_err(errA));

  ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(4)) dutB (
    .clk(clk), .clr(clr), .address(address), .data_in(dataIn), .read(rd), .write(wr),
    .data_out(dataOutB), .mem_ready(readyB), .addr_err(errB));

  // Reference model: plain word array plus the last value returned by a read
  logic [31:0] modelMem [512];
  logic [31:0] modelOut;

  // Per-access observations, index 0 = latency-1 instance, 1 = latency-4 instance
  int          pulses [2];
  int          cycSeen [2];
  logic [31:0] dSeen [2];
  logic        eSeen [2];
  int          bad [2];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, hold it for a fixed window, then drop it
  task automatic runAccess(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dS [2];
    logic        rS [2];
    logic        eS [2];
    for (int k = 0; k < 2; k++) begin
      pulses[k] = 0; cycSeen[k] = 0; dSeen[k] = '0; eSeen[k] = 1'b0; bad[k] = 0;
    end
    @(negedge clk);
    address = a; dataIn = d; rd = r; wr = w;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        address = ~a; dataIn = ~d;
      end
      dS[0] = dataOutA; rS[0] = readyA; eS[0] = errA;
      dS[1] = dataOutB; rS[1] = readyB; eS[1] = errB;
      for (int k = 0; k < 2; k++) begin
        if (rS[k] === 1'b1) begin
          pulses[k]++;
          cycSeen[k] = cyc;
          dSeen[k]   = dS[k];
          eSeen[k]   = eS[k];
        end else begin
          if (eS[k] !== 1'b0) bad[k]++;
          if (pulses[k] > 0 && dS[k] !== dSeen[k]) bad[k]++;
        end
      end
    end
    rd = 1'b0; wr = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  // Model prediction plus the bus transaction itself
  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] expData, output bit expErr);
    bit err;
    err = (a[31:9] != 23'd0);
    if (w) begin
      expData = modelOut;
      if (!err) modelMem[a[8:0]] = d;
    end else if (r) begin
      expData  = err ? 32'd0 : modelMem[a[8:0]];
      modelOut = expData;
    end else begin
      expData = modelOut;
    end
    expErr = err;
    runAccess(r, w, a, d);
  endtask

  task automatic checkAccess(input string tag, input bit isWrite, input logic [31:0] expData, input bit expErr);
    for (int k = 0; k < 2; k++) begin
      string s;
      int    lat;
      s   = (k == 0) ? "A" : "B";
      lat = isWrite ? 1 : ((k == 0) ? 1 : 4);
      checkOutput($sformatf("%s_%s_pulses", tag, s), 32'(pulses[k]), 32'd1);
      checkOutput($sformatf("%s_%s_latency", tag, s), 32'(cycSeen[k]), 32'(lat));
      checkOutput($sformatf("%s_%s_data", tag, s), dSeen[k], expData);
      checkOutput($sformatf("%s_%s_addr_err", tag, s), {31'd0, eSeen[k]}, {31'd0, expErr});
      checkOutput($sformatf("%s_%s_stable", tag, s), 32'(bad[k]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] expD;
    bit          expE;
    logic [31:0] pool [8];
    int          noPulse;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0087, 32'h0000_000D, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0087, 32'h0,         32'h0000_000D, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0095, 32'h0000_ABCD, 32'h0000_000D, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0095, 32'h0,         32'h0000_ABCD, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0043, 32'h0000_0043, 32'h0000_ABCD, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0043, 32'h0,         32'h0000_0043, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h5A5A_0000, 32'h0000_0043, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_DEAD, 32'h0000_0043, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h5A5A_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0087, 32'h0,         32'h0000_000D, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_01FF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0,         32'hFFFF_FFFF, 1'b0};

    modelOut = 32'd0;
    clr = 1'b1; rd = 1'b0; wr = 1'b0; address = '0; dataIn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_A_data", dataOutA, 32'd0);
    checkOutput("reset_A_ready", {31'd0, readyA}, 32'd0);
    checkOutput("reset_A_err", {31'd0, errA}, 32'd0);
    checkOutput("reset_B_data", dataOutB, 32'd0);
    checkOutput("reset_B_ready", {31'd0, readyB}, 32'd0);
    checkOutput("reset_B_err", {31'd0, errB}, 32'd0);
    clr = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, expD, expE);
      checkAccess($sformatf("vec%0d", i), vecs[i].wr, vecs[i].expData, vecs[i].expErr);
    end

    // Level-held read: a second request needs a drop in between
    applyStimulus(1'b1, 1'b0, 32'h0000_0095, 32'h0, expD, expE);
    checkAccess("hold1", 1'b0, 32'h0000_ABCD, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0095, 32'h0, expD, expE);
    checkAccess("hold2", 1'b0, 32'h0000_ABCD, 1'b0);

    // clr while the latency-4 instance is still counting
    @(negedge clk);
    address = 32'h0000_0087; rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_B_ready_before_clr", {31'd0, readyB}, 32'd0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_B_ready", {31'd0, readyB}, 32'd0);
    checkOutput("abort_B_data", dataOutB, 32'd0);
    checkOutput("abort_A_data", dataOutA, 32'd0);
    clr = 1'b0; rd = 1'b0;
    modelOut = 32'd0;
    noPulse = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (readyB !== 1'b0 || readyA !== 1'b0) noPulse++;
    end
    checkOutput("abort_no_late_pulse", 32'(noPulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0087, 32'h0, expD, expE);
    checkAccess("abort_preserved", 1'b0, 32'h0000_000D, 1'b0);

    // Randomised traffic over a small written pool plus out-of-range hits
    for (int i = 0; i < 8; i++) begin
      pool[i] = {23'd0, 9'($urandom_range(0, 511))};
      applyStimulus(1'b0, 1'b1, pool[i], $urandom, expD, expE);
      checkAccess($sformatf("fill%0d", i), 1'b1, expD, expE);
    end
    for (int i = 0; i < 20; i++) begin
      int          op;
      logic [31:0] a;
      bit          r, w;
      op = $urandom_range(0, 3);
      a  = pool[$urandom_range(0, 7)];
      r  = 1'b0; w = 1'b0;
      case (op)
        0: w = 1'b1;
        1, 2: r = 1'b1;
        default: begin
          a = {9'($urandom_range(1, 511)), 23'($urandom)};
          if ($urandom_range(0, 1) == 0) r = 1'b1; else w = 1'b1;
        end
      endcase
      applyStimulus(r, w, a, $urandom, expD, expE);
      checkAccess($sformatf("rand%0d", i), w, expD, expE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
